// File: rtl/mac_result_drain_pkg.sv
// Shared widths, FSM state type and the accumulator quantizer for mac_result_drain.
// Build macro MAC_DRAIN_ROUND_EN: defined = round-half-up, undefined = truncation.
package mac_pkg;
  localparam int ACC_W = 39;
  localparam int OUT_W = 16;

  typedef enum logic {ACC = 1'b0, DRAIN = 1'b1} drain_state_t;

  typedef struct packed {
    logic             sat;
    logic [OUT_W-1:0] data;
  } quant_t;

  // One extra bit above the accumulator keeps the rounding add from overflowing.
  function automatic quant_t quant(input logic [ACC_W-1:0] y, input int shift);
    logic [ACC_W:0] ext;
    logic [ACC_W:0] sh;
    quant_t         r;
    ext = {1'b0, y};
`ifdef MAC_DRAIN_ROUND_EN
    if (shift > 0) begin
      ext = ext + ({{ACC_W{1'b0}}, 1'b1} << (shift - 1));
    end else begin
      ext = ext;
    end
`endif
    sh = ext >> shift;
    if (|sh[ACC_W:OUT_W]) begin
      r.sat  = 1'b1;
      r.data = {OUT_W{1'b1}};
    end else begin
      r.sat  = 1'b0;
      r.data = sh[OUT_W-1:0];
    end
    return r;
  endfunction
endpackage

// File: rtl/mac_result_drain_if.sv
// Result handshake between the drain stage (master) and writeback logic (slave).
interface mac_result_drain_if;
  logic [mac_pkg::OUT_W-1:0] out_data;
  logic                      out_valid;
  logic                      out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/mac_result_drain_out_fifo2.sv
// Two-entry result FIFO; the head entry is a register that feeds out_data directly.
module out_fifo2 import mac_pkg::*; #(
  parameter int W = OUT_W
) (
  input  logic         clk,
  input  logic         R,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic         head_vld;
  logic         tail_vld;
  logic         push_ok;
  logic         pop_ok;

  assign push_ok = push & ~tail_vld;
  assign pop_ok  = pop & head_vld;
  assign dout    = head;
  assign full    = tail_vld;
  assign empty   = ~head_vld;

  // Occupancy is encoded by the two valid bits; tail is only ever valid behind a valid head.
  always_ff @(posedge clk) begin
    if (R) begin
      head     <= '0;
      tail     <= '0;
      head_vld <= 1'b0;
      tail_vld <= 1'b0;
    end else begin
      case ({push_ok, pop_ok})
        2'b01: begin
          head     <= tail;
          head_vld <= tail_vld;
          tail_vld <= 1'b0;
        end
        2'b10: begin
          if (!head_vld) begin
            head     <= din;
            head_vld <= 1'b1;
          end else begin
            tail     <= din;
            tail_vld <= 1'b1;
          end
        end
        2'b11: head <= din;
        default: head <= head;
      endcase
    end
  end
endmodule

// File: rtl/mac_result_drain.sv
// Drain stage for the MAC: counts vector pairs, captures/clears the accumulator, quantizes, queues.
// Rounding is selected at build time by MAC_DRAIN_ROUND_EN (see mac_pkg::quant).
module mac_result_drain import mac_pkg::*; #(
  parameter int SHIFT = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             R,
  input  logic             valid_in,
  input  logic [LEN_W-1:0] vec_len,
  input  logic [ACC_W-1:0] y,
  output logic             in_ready,
  output logic             acc_clr,
  output logic             sat_flag,
  mac_result_drain_if.master res
);
  localparam logic [LEN_W-1:0] ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  drain_state_t     state;
  drain_state_t     state_nx;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_live;
  logic [LEN_W-1:0] target;
  logic [LEN_W-1:0] cnt_inc;
  logic             last;
  logic             full;
  logic             empty;
  quant_t           q;

  assign q = quant(y, SHIFT);

  // State register
  always_ff @(posedge clk) begin
    if (R) begin
      state <= ACC;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and handshake outputs; the first pair of a vector compares against the live length
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    acc_clr  = 1'b0;
    last     = 1'b0;
    len_live = (vec_len == '0) ? ONE : vec_len;
    target   = (cnt == '0) ? len_live : len_q;
    cnt_inc  = cnt + ONE;
    case (state)
      ACC: begin
        in_ready = 1'b1;
        if (valid_in && (cnt_inc == target)) begin
          last     = 1'b1;
          state_nx = DRAIN;
        end else begin
          state_nx = ACC;
        end
      end
      DRAIN: begin
        acc_clr = ~full;
        if (!full) begin
          state_nx = ACC;
        end else begin
          state_nx = DRAIN;
        end
      end
      default: state_nx = ACC;
    endcase
  end

  // Pair counter and latched vector length
  always_ff @(posedge clk) begin
    if (R) begin
      cnt   <= '0;
      len_q <= ONE;
    end else if ((state == ACC) && valid_in) begin
      if (cnt == '0) begin
        len_q <= len_live;
      end else begin
        len_q <= len_q;
      end
      if (last) begin
        cnt <= '0;
      end else begin
        cnt <= cnt_inc;
      end
    end else begin
      cnt   <= cnt;
      len_q <= len_q;
    end
  end

  // Sticky saturation indicator, updated only on a capture
  always_ff @(posedge clk) begin
    if (R) begin
      sat_flag <= 1'b0;
    end else if (acc_clr && q.sat) begin
      sat_flag <= 1'b1;
    end else begin
      sat_flag <= sat_flag;
    end
  end

  out_fifo2 #(.W(OUT_W)) u_fifo (
    .clk   (clk),
    .R     (R),
    .push  (acc_clr),
    .din   (q.data),
    .pop   (res.out_valid & res.out_ready),
    .dout  (res.out_data),
    .full  (full),
    .empty (empty)
  );

  assign res.out_valid = ~empty;
endmodule

// File: tb/tb_mac_result_drain.sv
// Bench for mac_result_drain: MAC stand-in, queue-based result model, directed and random stimulus.
module tb_mac_result_drain;
  import mac_pkg::*;

  localparam int SH = 2;
`ifdef MAC_DRAIN_ROUND_EN
  localparam logic [15:0] T1_EXP = 16'd19;
  localparam logic [15:0] T5_EXP = 16'd8;
`else
  localparam logic [15:0] T1_EXP = 16'd18;
  localparam logic [15:0] T5_EXP = 16'd7;
`endif

  logic             clk = 1'b0;
  logic             R = 1'b1;
  logic             valid_in = 1'b0;
  logic [7:0]       vec_len = 8'd1;
  logic [ACC_W-1:0] y;
  logic [15:0]      op_a = 16'd0;
  logic [15:0]      op_b = 16'd0;
  logic [31:0]      prod;
  logic             in_ready;
  logic             acc_clr;
  logic             sat_flag;
  logic             rand_mode = 1'b0;
  logic             rnd_rdy = 1'b0;
  logic             dir_rdy = 1'b1;

  int checks = 0;
  int errors = 0;

  mac_result_drain_if res();
  assign res.out_ready = rand_mode ? rnd_rdy : dir_rdy;

  mac_result_drain #(.SHIFT(SH), .LEN_W(8)) dut (
    .clk      (clk),
    .R        (R),
    .valid_in (valid_in),
    .vec_len  (vec_len),
    .y        (y),
    .in_ready (in_ready),
    .acc_clr  (acc_clr),
    .sat_flag (sat_flag),
    .res      (res)
  );

  always #5 clk = ~clk;

  assign prod = op_a * op_b;

  // MAC stand-in: clear is R ORed with acc_clr
  always @(posedge clk) begin
    if (R || acc_clr) y <= '0;
    else if (valid_in) y <= y + {7'd0, prod};
  end

  always @(posedge clk) rnd_rdy <= 1'($urandom_range(0, 1));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Expected result: {sat, data}
  function automatic logic [16:0] ref_quant(input longint v);
    longint r;
    r = v;
`ifdef MAC_DRAIN_ROUND_EN
    if (SH > 0) r = r + (longint'(1) << (SH - 1));
`endif
    r = r / (longint'(1) << SH);
    if (r > 65535) return {1'b1, 16'hFFFF};
    return {1'b0, 16'(r)};
  endfunction

  logic [16:0] expq[$];
  int          mcnt = 0;
  int          mlen = 1;
  longint      msum = 0;
  bit          msat_any = 1'b0;

  // Reference model and per-cycle compare
  always @(negedge clk) begin
    logic [16:0] qv;
    if (R) begin
      expq.delete();
      mcnt = 0;
      msum = 0;
      msat_any = 1'b0;
    end else begin
      chk("ready_clr_exclusive", {63'd0, in_ready & acc_clr}, 64'd0);
      if (!msat_any) chk("sat_idle", {63'd0, sat_flag}, 64'd0);
      if (res.out_valid) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL spurious_out actual=valid required=idle data=%0h", res.out_data);
        end else begin
          if (res.out_data !== expq[0][15:0]) begin
            errors++;
            $display("FAIL out_data actual=%0h required=%0h", res.out_data, expq[0][15:0]);
          end
          if (expq[0][16]) chk("sat_on_pop", {63'd0, sat_flag}, 64'd1);
          if (res.out_ready) void'(expq.pop_front());
        end
      end
      if (valid_in && in_ready) begin
        if (mcnt == 0) mlen = (vec_len == 8'd0) ? 1 : int'(vec_len);
        msum = msum + longint'(prod);
        mcnt++;
        if (mcnt == mlen) begin
          qv = ref_quant(msum);
          expq.push_back(qv);
          if (qv[16]) msat_any = 1'b1;
          mcnt = 0;
          msum = 0;
        end
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 right after the pair was sampled
  task automatic feed(input logic [15:0] a, input logic [15:0] b);
    int w;
    w = 0;
    while (!in_ready && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL feed_wait actual=in_ready_low required=in_ready_high");
    end else begin
      valid_in = 1'b1;
      op_a = a;
      op_b = b;
      @(posedge clk); #1;
      valid_in = 1'b0;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_acc_clr", {63'd0, acc_clr}, 64'd0);
    chk("rst_out_valid", {63'd0, res.out_valid}, 64'd0);
    chk("rst_out_data", {48'd0, res.out_data}, 64'd0);
    chk("rst_sat", {63'd0, sat_flag}, 64'd0);
    R = 1'b0;

    // Basic vector, y = 75
    vec_len = 8'd4;
    feed(16'd2, 16'd3); feed(16'd5, 16'd4); feed(16'd1, 16'd1); feed(16'd16, 16'd3);
    chk("t1_drain_in_ready", {63'd0, in_ready}, 64'd0);
    chk("t1_drain_clr", {63'd0, acc_clr}, 64'd1);
    tick(1);
    chk("t1_in_ready_back", {63'd0, in_ready}, 64'd1);
    chk("t1_out_valid", {63'd0, res.out_valid}, 64'd1);
    chk("t1_out_data", {48'd0, res.out_data}, {48'd0, T1_EXP});
    tick(1);
    chk("t1_popped", {63'd0, res.out_valid}, 64'd0);

    // Saturation, sticky
    vec_len = 8'd1;
    feed(16'hFFFF, 16'hFFFF);
    chk("t2_clr", {63'd0, acc_clr}, 64'd1);
    tick(1);
    chk("t2_out_data", {48'd0, res.out_data}, 64'h0000_0000_0000_FFFF);
    chk("t2_sat", {63'd0, sat_flag}, 64'd1);
    feed(16'd1, 16'd1);
    tick(3);
    chk("t2_sat_sticky", {63'd0, sat_flag}, 64'd1);

    // Backpressure: results 6, 28, 16
    dir_rdy = 1'b0;
    vec_len = 8'd2;
    feed(16'd4, 16'd5); feed(16'd2, 16'd2);
    feed(16'd10, 16'd10); feed(16'd3, 16'd4);
    feed(16'd8, 16'd8); feed(16'd0, 16'd1);
    chk("t3_hold_in_ready", {63'd0, in_ready}, 64'd0);
    chk("t3_hold_clr", {63'd0, acc_clr}, 64'd0);
    tick(3);
    chk("t3_still_hold", {62'd0, in_ready, acc_clr}, 64'd0);
    chk("t3_head", {48'd0, res.out_data}, 64'd6);
    dir_rdy = 1'b1;
    tick(1);
    chk("t3_second", {48'd0, res.out_data}, 64'd28);
    chk("t3_release_clr", {63'd0, acc_clr}, 64'd1);
    tick(1);
    chk("t3_third_valid", {63'd0, res.out_valid}, 64'd1);
    chk("t3_third", {48'd0, res.out_data}, 64'd16);
    tick(1);
    chk("t3_empty", {63'd0, res.out_valid}, 64'd0);

    // Zero length behaves as one
    vec_len = 8'd0;
    for (int i = 0; i < 3; i++) begin
      feed(16'($urandom_range(0, 999)), 16'($urandom_range(0, 999)));
      chk("t4_len0_clr", {63'd0, acc_clr}, 64'd1);
    end

    // Reset mid-vector, then 1+4+9+16 = 30
    vec_len = 8'd4;
    feed(16'd7, 16'd7); feed(16'd9, 16'd9);
    R = 1'b1;
    tick(1);
    R = 1'b0;
    chk("t5_in_ready", {63'd0, in_ready}, 64'd1);
    chk("t5_clr", {63'd0, acc_clr}, 64'd0);
    chk("t5_out_valid", {63'd0, res.out_valid}, 64'd0);
    chk("t5_out_data", {48'd0, res.out_data}, 64'd0);
    chk("t5_sat", {63'd0, sat_flag}, 64'd0);
    feed(16'd1, 16'd1); feed(16'd2, 16'd2); feed(16'd3, 16'd3); feed(16'd4, 16'd4);
    tick(1);
    chk("t5_result", {47'd0, res.out_valid, res.out_data}, {47'd0, 1'b1, T5_EXP});

    // Length change mid-vector only affects the next vector
    vec_len = 8'd3;
    feed(16'd1, 16'd2);
    vec_len = 8'd2;
    feed(16'd3, 16'd4);
    chk("t6_no_early_drain", {62'd0, in_ready, acc_clr}, 64'd2);
    feed(16'd5, 16'd6);
    chk("t6_v1_end", {63'd0, acc_clr}, 64'd1);
    feed(16'd2, 16'd2);
    chk("t6_v2_mid", {63'd0, acc_clr}, 64'd0);
    feed(16'd3, 16'd3);
    chk("t6_v2_end", {63'd0, acc_clr}, 64'd1);

    // Random traffic with random backpressure and mid-vector length changes
    rand_mode = 1'b1;
    for (int i = 0; i < 600; i++) begin
      vec_len = 8'($urandom_range(0, 5));
      if ($urandom_range(0, 7) == 0)
        feed(16'($urandom_range(40000, 65535)), 16'($urandom_range(40000, 65535)));
      else
        feed(16'($urandom_range(0, 700)), 16'($urandom_range(0, 700)));
      if ($urandom_range(0, 2) == 0) tick($urandom_range(1, 3));
    end
    rand_mode = 1'b0;
    tick(20);
    chk("queue_drained", 64'(expq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
